// File: rtl/cic_pkg.sv
// Shared sizing helpers and default register width for the CIC decimator.
package cic_pkg;

    localparam int unsigned DEF_STAGES        = 3;
    localparam int unsigned DEF_MAX_RATE_LOG2 = 4;
    localparam int unsigned DEF_IN_WIDTH      = 1;

    // Register width that holds the worst-case CIC gain without overflow ambiguity
    function automatic int unsigned cic_reg_width(input int unsigned in_w,
                                                  input int unsigned stages,
                                                  input int unsigned max_log2);
        return in_w + stages * max_log2;
    endfunction

    // Limit a requested decimation exponent to the supported maximum
    function automatic int unsigned clamp_rate(input int unsigned rate,
                                               input int unsigned max_log2);
        return (rate > max_log2) ? max_log2 : rate;
    endfunction

    localparam int unsigned W = cic_reg_width(DEF_IN_WIDTH, DEF_STAGES, DEF_MAX_RATE_LOG2);

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: registered delay of the input and combinational difference.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int unsigned WIDTH = W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] diff_c
);

    logic [WIDTH-1:0] delay_r;

    // Modulo-2^WIDTH difference against the previous decimated sample
    assign diff_c = din - delay_r;

    // Delay register advances only on the decimation strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_r <= '0;
        end else if (clear) begin
            delay_r <= '0;
        end else if (en) begin
            delay_r <= din;
        end
    end

endmodule

// File: rtl/cic_decimator_param.sv
// N-stage CIC decimator with runtime power-of-two rate, normalised output and settle flag.
module cic_decimator_param
    import cic_pkg::*;
#(
    parameter int unsigned STAGES        = 3,
    parameter int unsigned MAX_RATE_LOG2 = 4,
    parameter int unsigned IN_WIDTH      = 1,
    parameter int unsigned OUT_WIDTH     = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clear,
    input  logic [$clog2(MAX_RATE_LOG2+1)-1:0] rate_log2,
    input  logic                               in_valid,
    input  logic [IN_WIDTH-1:0]                in_data,
    output logic                               out_valid,
    output logic [OUT_WIDTH-1:0]               out_data,
    output logic                               settled
);

    localparam int unsigned RATE_W = $clog2(MAX_RATE_LOG2 + 1);
    localparam int unsigned REG_W  = cic_reg_width(IN_WIDTH, STAGES, MAX_RATE_LOG2);
    localparam int unsigned CTR_W  = (MAX_RATE_LOG2 > 0) ? MAX_RATE_LOG2 : 1;
    localparam int unsigned SET_W  = $clog2(STAGES + 1);
    localparam int unsigned NORM_W = REG_W + OUT_WIDTH;

    logic [RATE_W-1:0]    rate_r;
    logic [RATE_W-1:0]    rate_clamped_c;
    logic                 accept_c;
    logic [CTR_W-1:0]     ctr_r;
    logic [CTR_W-1:0]     ctr_last_c;
    logic                 dec_tick;
    logic [REG_W-1:0]     integ_last_c;
    logic [REG_W-1:0]     comb_out_c;
    logic [31:0]          eff_w_c;
    logic [NORM_W-1:0]    comb_ext_c;
    logic [OUT_WIDTH-1:0] norm_c;
    logic [SET_W-1:0]     set_cnt_r;

    assign rate_clamped_c = RATE_W'(clamp_rate(32'(rate_log2), MAX_RATE_LOG2));
    assign accept_c       = in_valid && !clear;
    assign ctr_last_c     = CTR_W'((32'd1 << rate_r) - 32'd1);

    // Rate follows the input while in reset and is re-latched only on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_r <= rate_clamped_c;
        end else if (clear) begin
            rate_r <= rate_clamped_c;
        end
    end

    // Cascaded integrators; each stage adds the freshly updated value of the previous one
    for (genvar g = 0; g < int'(STAGES); g++) begin : g_integ
        logic [REG_W-1:0] acc_r;
        logic [REG_W-1:0] sum_c;

        if (g == 0) begin : g_first
            assign sum_c = acc_r + REG_W'(in_data);
        end else begin : g_next
            assign sum_c = acc_r + g_integ[g-1].sum_c;
        end

        // Integrator state, wraps modulo 2^REG_W by design
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_r <= '0;
            end else if (clear) begin
                acc_r <= '0;
            end else if (accept_c) begin
                acc_r <= sum_c;
            end
        end
    end

    assign integ_last_c = g_integ[STAGES-1].acc_r;

    // Accepted-sample counter producing the one-cycle decimation strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_r    <= '0;
            dec_tick <= 1'b0;
        end else if (clear) begin
            ctr_r    <= '0;
            dec_tick <= 1'b0;
        end else begin
            dec_tick <= 1'b0;
            if (accept_c) begin
                if (ctr_r == ctr_last_c) begin
                    ctr_r    <= '0;
                    dec_tick <= 1'b1;
                end else begin
                    ctr_r <= ctr_r + CTR_W'(1);
                end
            end
        end
    end

    // Comb chain fed from the last integrator, advanced on the decimation strobe
    for (genvar g = 0; g < int'(STAGES); g++) begin : g_comb
        logic [REG_W-1:0] din_c;
        logic [REG_W-1:0] diff_c;

        if (g == 0) begin : g_first
            assign din_c = integ_last_c;
        end else begin : g_next
            assign din_c = g_comb[g-1].diff_c;
        end

        cic_comb_stage #(
            .WIDTH (REG_W)
        ) u_comb (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (clear),
            .en     (dec_tick),
            .din    (din_c),
            .diff_c (diff_c)
        );
    end

    assign comb_out_c = g_comb[STAGES-1].diff_c;

    // Align the effective gain width E = IN_WIDTH + STAGES*rate to OUT_WIDTH bits
    always_comb begin
        eff_w_c    = IN_WIDTH + STAGES * 32'(rate_r);
        comb_ext_c = NORM_W'(comb_out_c);
        norm_c     = '0;
        if (eff_w_c >= OUT_WIDTH) begin
            norm_c = OUT_WIDTH'(comb_ext_c >> (eff_w_c - OUT_WIDTH));
        end else begin
            norm_c = OUT_WIDTH'(comb_ext_c << (OUT_WIDTH - eff_w_c));
        end
    end

    // Output register, valid strobe and saturating settle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            settled   <= 1'b0;
            set_cnt_r <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            settled   <= 1'b0;
            set_cnt_r <= '0;
        end else begin
            out_valid <= dec_tick;
            if (dec_tick) begin
                out_data <= norm_c;
                if (32'(set_cnt_r) < STAGES) begin
                    set_cnt_r <= set_cnt_r + SET_W'(1);
                end
                if (32'(set_cnt_r) + 32'd1 >= STAGES) begin
                    settled <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator_param.sv
// Self-checking bench: FIR-equivalent reference model plus directed vector table.
module tb_cic_decimator_param;

    localparam int unsigned STAGES = 3;
    localparam int unsigned MAXR   = 4;
    localparam int unsigned IN_W   = 1;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned RATE_W = 3;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic [RATE_W-1:0] rate_log2;
    logic              in_valid;
    logic [IN_W-1:0]   in_data;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic              settled;

    cic_decimator_param #(
        .STAGES        (STAGES),
        .MAX_RATE_LOG2 (MAXR),
        .IN_WIDTH      (IN_W),
        .OUT_WIDTH     (OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .rate_log2 (rate_log2),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .settled   (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc_no   = 0;

    // Reference model: the CIC is an FIR with taps of ((1-z^-R)/(1-z^-1))^N, sampled every R inputs
    int m_rate;
    int m_r;
    int h[0:63];
    int h_len;
    int hist[$];
    int m_acc;
    bit m_tick;
    int m_pend;
    bit m_ov;
    int m_od;
    int m_outs;
    bit m_settled;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc_no, act, exp);
        end
    endtask

    task automatic model_reset();
        int tmp[0:63];
        m_rate = (int'(rate_log2) > int'(MAXR)) ? int'(MAXR) : int'(rate_log2);
        m_r    = 1 << m_rate;
        for (int i = 0; i < 64; i++) h[i] = 0;
        h[0]  = 1;
        h_len = 1;
        for (int s = 0; s < int'(STAGES); s++) begin
            for (int i = 0; i < 64; i++) tmp[i] = 0;
            for (int i = 0; i < h_len + m_r - 1; i++)
                for (int k = 0; k < m_r; k++)
                    if (i - k >= 0 && i - k < h_len) tmp[i] += h[i-k];
            h_len = h_len + m_r - 1;
            for (int i = 0; i < 64; i++) h[i] = tmp[i];
        end
        hist.delete();
        m_acc     = 0;
        m_tick    = 1'b0;
        m_pend    = 0;
        m_ov      = 1'b0;
        m_od      = 0;
        m_outs    = 0;
        m_settled = 1'b0;
    endtask

    function automatic int model_value();
        int y = 0;
        int e;
        int n = hist.size();
        for (int j = 0; j < h_len; j++)
            if (n - 1 - j >= 0) y += h[j] * hist[n-1-j];
        e = int'(IN_W) + int'(STAGES) * m_rate;
        if (e >= int'(OUT_W)) return (y >> (e - int'(OUT_W))) & 255;
        else return (y << (int'(OUT_W) - e)) & 255;
    endfunction

    task automatic model_edge();
        if (!rst_n || clear) begin
            model_reset();
        end else begin
            m_ov = m_tick;
            if (m_tick) begin
                m_od      = m_pend;
                m_outs++;
                m_settled = (m_outs >= int'(STAGES));
            end
            m_tick = 1'b0;
            if (in_valid) begin
                hist.push_back(int'(in_data));
                if (hist.size() > 64) void'(hist.pop_front());
                m_acc++;
                if (m_acc == m_r) begin
                    m_acc  = 0;
                    m_tick = 1'b1;
                    m_pend = model_value();
                end
            end
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare on the falling edge
    task automatic cyc(input logic v, input logic [IN_W-1:0] d, input logic clr);
        in_valid = v;
        in_data  = d;
        clear    = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc_no++;
        chk("out_valid", int'(out_valid), int'(m_ov));
        chk("out_data",  int'(out_data),  m_od);
        chk("settled",   int'(settled),   int'(m_settled));
    endtask

    typedef struct {
        int         rate;
        int         pat;
        int         cycles;
        bit         chk_final;
        logic [7:0] exp_data;
        int         exp_period;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int last_ov;
        int prev_ov;
        int k;
        int ov_cnt;
        logic v;
        logic [IN_W-1:0] d;
        bit found;

        // pat: 0 const 0, 1 const 1, 2 alternating 1/0, 3 random valid with 1, 4 random data
        vecs[0] = '{2, 1,  200, 1'b1, 8'h80,  4};
        vecs[1] = '{2, 2,  200, 1'b1, 8'h40,  4};
        vecs[2] = '{2, 0,  100, 1'b1, 8'h00,  4};
        vecs[3] = '{4, 1, 2000, 1'b1, 8'h80, 16};
        vecs[4] = '{2, 3,  400, 1'b1, 8'h80,  0};
        vecs[5] = '{0, 1,   60, 1'b1, 8'h80,  1};
        vecs[6] = '{1, 1,  100, 1'b1, 8'h80,  2};
        vecs[7] = '{3, 1,  200, 1'b1, 8'h80,  8};
        vecs[8] = '{4, 4,  600, 1'b0, 8'h00, 16};
        vecs[9] = '{7, 1,  300, 1'b1, 8'h80, 16};

        rst_n     = 1'b0;
        clear     = 1'b0;
        rate_log2 = 3'd2;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Directed table with the model running alongside
        for (int t = 0; t < 10; t++) begin
            rate_log2 = RATE_W'(vecs[t].rate);
            cyc(1'b0, '0, 1'b1);
            chk("settled_after_clear", int'(settled), 0);
            last_ov = -1;
            prev_ov = -1;
            k       = 0;
            for (int i = 0; i < vecs[t].cycles; i++) begin
                case (vecs[t].pat)
                    0:       begin v = 1'b1; d = 1'b0; end
                    1:       begin v = 1'b1; d = 1'b1; end
                    2:       begin v = 1'b1; d = (k % 2 == 0) ? 1'b1 : 1'b0; k++; end
                    3:       begin v = 1'($urandom_range(0, 1)); d = 1'b1; end
                    default: begin v = 1'b1; d = 1'($urandom_range(0, 1)); end
                endcase
                cyc(v, d, 1'b0);
                if (out_valid) begin
                    prev_ov = last_ov;
                    last_ov = cyc_no;
                end
            end
            if (vecs[t].chk_final) begin
                chk("final_data", int'(out_data), int'(vecs[t].exp_data));
                chk("final_settled", int'(settled), 1);
            end
            if (vecs[t].exp_period != 0)
                chk("period", last_ov - prev_ov, vecs[t].exp_period);
        end

        // Rate change without clear is ignored (still R=16 from clamped 7)
        rate_log2 = 3'd1;
        last_ov   = -1;
        prev_ov   = -1;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (out_valid) begin
                prev_ov = last_ov;
                last_ov = cyc_no;
            end
        end
        chk("ignored_rate_period", last_ov - prev_ov, 16);
        chk("ignored_rate_data", int'(out_data), 8'h80);

        // Clear re-latches R=2; the sample presented with clear is dropped
        cyc(1'b1, 1'b1, 1'b1);
        chk("clear_settled_drop", int'(settled), 0);
        ov_cnt = 0;
        found  = 1'b0;
        for (int j = 1; j <= 100 && !found; j++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (out_valid) begin
                ov_cnt++;
                if (ov_cnt == 3) begin
                    found = 1'b1;
                    chk("third_pulse_cycle", j, 7);
                    chk("third_pulse_settled", int'(settled), 1);
                    chk("third_pulse_data", int'(out_data), 8'h80);
                end
            end
        end
        chk("third_pulse_seen", int'(found), 1);

        // Reset asserted while the decimation strobe is pending: no output may follow
        rate_log2 = 3'd2;
        cyc(1'b0, '0, 1'b1);
        repeat (4) cyc(1'b1, 1'b1, 1'b0);
        rst_n  = 1'b0;
        ov_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b0);
            if (out_valid) ov_cnt++;
            chk("rst_low_data", int'(out_data), 0);
            chk("rst_low_settled", int'(settled), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (out_valid) ov_cnt++;
            chk("post_rst_data", int'(out_data), 0);
        end
        chk("no_out_valid_after_rst", ov_cnt, 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("tick_not_yet", int'(out_valid), 0);
        cyc(1'b0, '0, 1'b0);
        chk("first_out_after_rst", int'(out_valid), 1);
        repeat (4) cyc(1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
